// File: rtl/sfx_scheduler.sv
// -----------------------------------------------------------------------------
// sfx_scheduler
//
// Sound-effect scheduler between game logic and the codec playback datapath.
// Three one-shot sources (0 coin, 1 win, 2 gameover) raise play requests that
// are held in a one-deep pending flag per source. On each audio frame tick the
// scheduler starts, preempts, retriggers or advances the active clip and drives
// the sample ROM address, read enable and one-hot clip select.
//
// Handshake / strobe semantics: i_req bits and i_stop are single-cycle pulses
// sampled on every rising clk edge; there is no back-pressure. A request is
// latched into pending on the edge that ends its cycle and is only seen by
// arbitration from the following cycle onward. All playback decisions happen
// only in cycles where i_sample_tick is high; i_stop acts on any cycle and
// wins over a same-cycle tick and request.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   i_cfg_done     codec configured; gates new starts from IDLE only
//   i_sample_tick  one-cycle strobe per LR frame
//   i_req[2:0]     play-request pulses (bit0 coin, bit1 win, bit2 gameover)
//   i_stop         abort current clip and flush pending requests
//   o_rom_addr     sample address of the active clip (0 when idle)
//   o_rom_sel      one-hot active clip select (0 when idle)
//   o_rom_rden     ROM read enable, high while playing
//   o_playing      a clip is active
//   o_done[2:0]    one-cycle pulse when a clip completes naturally
//   o_dbg_state    FSM state (0 IDLE, 1 PLAY)
//   o_dbg_pending  pending request flags
// -----------------------------------------------------------------------------
module sfx_scheduler #(
    parameter int ADDR_W = 18,
    parameter int LEN0   = 10095,
    parameter int LEN1   = 50796,
    parameter int LEN2   = 17197
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cfg_done,
    input  logic              i_sample_tick,
    input  logic [2:0]        i_req,
    input  logic              i_stop,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic [2:0]        o_rom_sel,
    output logic              o_rom_rden,
    output logic              o_playing,
    output logic [2:0]        o_done,
    output logic              o_dbg_state,
    output logic [2:0]        o_dbg_pending
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    // Last valid address of each clip; lengths up to 2^ADDR_W fit after -1.
    localparam logic [ADDR_W-1:0] LAST0 = ADDR_W'(LEN0 - 1);
    localparam logic [ADDR_W-1:0] LAST1 = ADDR_W'(LEN1 - 1);
    localparam logic [ADDR_W-1:0] LAST2 = ADDR_W'(LEN2 - 1);

    state_t            r_state;
    logic [2:0]        r_pending;
    logic [1:0]        r_cur;
    logic [2:0]        r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_done;

    state_t            w_state_nx;
    logic [2:0]        w_pending_nx;
    logic [1:0]        w_cur_nx;
    logic [2:0]        w_sel_nx;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [2:0]        w_done_nx;

    logic [ADDR_W-1:0] w_last_addr;
    logic [2:0]        w_ge_mask;
    logic [2:0]        w_cand;
    logic [1:0]        w_hi_pend;
    logic [1:0]        w_hi_cand;
    logic              w_start;
    logic [1:0]        w_start_idx;
    logic [2:0]        w_pend_clr;

    // Arbitration helpers. w_cand holds the pending sources allowed to take
    // over a running clip: anything of higher priority, or the running source
    // itself (retrigger).
    always_comb begin
        w_last_addr = LAST0;
        w_ge_mask   = 3'b111;
        case (r_cur)
            2'd0:    begin w_last_addr = LAST0; w_ge_mask = 3'b111; end
            2'd1:    begin w_last_addr = LAST1; w_ge_mask = 3'b110; end
            default: begin w_last_addr = LAST2; w_ge_mask = 3'b100; end
        endcase
        w_cand = r_pending & w_ge_mask;
        w_hi_pend = r_pending[2] ? 2'd2 : (r_pending[1] ? 2'd1 : 2'd0);
        w_hi_cand = w_cand[2]    ? 2'd2 : (w_cand[1]    ? 2'd1 : 2'd0);
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cur_nx     = r_cur;
        w_sel_nx     = r_sel;
        w_addr_nx    = r_addr;
        w_done_nx    = 3'b000;
        w_start      = 1'b0;
        w_start_idx  = 2'd0;
        w_pend_clr   = 3'b000;
        w_pending_nx = r_pending;

        case (r_state)
            S_IDLE: begin
                if (i_sample_tick && i_cfg_done && (r_pending != 3'b000)) begin
                    w_start     = 1'b1;
                    w_start_idx = w_hi_pend;
                end
            end
            default: begin
                if (i_sample_tick) begin
                    if (w_cand != 3'b000) begin
                        // Preempted clip is dropped without a done pulse.
                        w_start     = 1'b1;
                        w_start_idx = w_hi_cand;
                    end else if (r_addr == w_last_addr) begin
                        w_done_nx = 3'b001 << r_cur;
                        if (r_pending != 3'b000) begin
                            // Chain straight into the next clip, no silent frame.
                            w_start     = 1'b1;
                            w_start_idx = w_hi_pend;
                        end else begin
                            w_state_nx = S_IDLE;
                            w_sel_nx   = 3'b000;
                            w_addr_nx  = '0;
                        end
                    end else begin
                        w_addr_nx = r_addr + 1'b1;
                    end
                end
            end
        endcase

        if (w_start) begin
            w_state_nx = S_PLAY;
            w_cur_nx   = w_start_idx;
            w_sel_nx   = 3'b001 << w_start_idx;
            w_addr_nx  = '0;
            w_pend_clr = 3'b001 << w_start_idx;
        end

        w_pending_nx = (r_pending & ~w_pend_clr) | i_req;

        // Stop wins over everything in the same cycle, including new requests.
        if (i_stop) begin
            w_state_nx   = S_IDLE;
            w_sel_nx     = 3'b000;
            w_addr_nx    = '0;
            w_done_nx    = 3'b000;
            w_pending_nx = 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pending <= 3'b000;
            r_cur     <= 2'd0;
            r_sel     <= 3'b000;
            r_addr    <= '0;
            r_done    <= 3'b000;
        end else begin
            r_state   <= w_state_nx;
            r_pending <= w_pending_nx;
            r_cur     <= w_cur_nx;
            r_sel     <= w_sel_nx;
            r_addr    <= w_addr_nx;
            r_done    <= w_done_nx;
        end
    end

    assign o_rom_addr    = r_addr;
    assign o_rom_sel     = r_sel;
    assign o_rom_rden    = (r_state == S_PLAY);
    assign o_playing     = (r_state == S_PLAY);
    assign o_done        = r_done;
    assign o_dbg_state   = r_state;
    assign o_dbg_pending = r_pending;

endmodule

// File: tb/tb_sfx_scheduler.sv
// -----------------------------------------------------------------------------
// Directed testbench for sfx_scheduler with short clips (coin 4, win 6,
// gameover 3 samples). Each scenario task drives cycles and checks outputs
// 1 ns after the rising edge against hand-computed values.
// -----------------------------------------------------------------------------
module tb_sfx_scheduler;

    localparam int ADDR_W = 18;

    logic              clk;
    logic              reset;
    logic              i_cfg_done;
    logic              i_sample_tick;
    logic [2:0]        i_req;
    logic              i_stop;
    logic [ADDR_W-1:0] o_rom_addr;
    logic [2:0]        o_rom_sel;
    logic              o_rom_rden;
    logic              o_playing;
    logic [2:0]        o_done;
    logic              o_dbg_state;
    logic [2:0]        o_dbg_pending;

    int n_cmp = 0;
    int n_err = 0;

    sfx_scheduler #(
        .ADDR_W(ADDR_W), .LEN0(4), .LEN1(6), .LEN2(3)
    ) dut (
        .clk(clk), .reset(reset), .i_cfg_done(i_cfg_done),
        .i_sample_tick(i_sample_tick), .i_req(i_req), .i_stop(i_stop),
        .o_rom_addr(o_rom_addr), .o_rom_sel(o_rom_sel), .o_rom_rden(o_rom_rden),
        .o_playing(o_playing), .o_done(o_done), .o_dbg_state(o_dbg_state),
        .o_dbg_pending(o_dbg_pending)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver ----------------
    // One clock cycle with the given strobes; returns 1 ns after the edge.
    task automatic cyc(input logic t, input logic [2:0] r, input logic s);
        @(negedge clk);
        i_sample_tick = t;
        i_req         = r;
        i_stop        = s;
        @(posedge clk);
        #1;
        i_sample_tick = 1'b0;
        i_req         = 3'b000;
        i_stop        = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1;
        cyc(1'b0, 3'b000, 1'b0);
        cyc(1'b0, 3'b000, 1'b0);
        reset = 1'b0;
        n_cmp++; if (o_playing !== 1'b0) begin n_err++; $display("FAIL rst_playing: got %b want 0", o_playing); end
        n_cmp++; if (o_rom_rden !== 1'b0) begin n_err++; $display("FAIL rst_rden: got %b want 0", o_rom_rden); end
        n_cmp++; if (o_rom_sel !== 3'b000) begin n_err++; $display("FAIL rst_sel: got %b want 000", o_rom_sel); end
        n_cmp++; if (o_rom_addr !== 18'd0) begin n_err++; $display("FAIL rst_addr: got %0d want 0", o_rom_addr); end
        n_cmp++; if (o_done !== 3'b000) begin n_err++; $display("FAIL rst_done: got %b want 000", o_done); end
        n_cmp++; if (o_dbg_pending !== 3'b000) begin n_err++; $display("FAIL rst_pending: got %b want 000", o_dbg_pending); end
        n_cmp++; if (o_dbg_state !== 1'b0) begin n_err++; $display("FAIL rst_state: got %b want 0", o_dbg_state); end
    endtask

    task automatic test_cfg_gate;
        i_cfg_done = 1'b0;
        cyc(1'b0, 3'b001, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 3'b000, 1'b0);
            n_cmp++; if (o_playing !== 1'b0) begin n_err++; $display("FAIL cfg_blocked_playing tick%0d: got %b want 0", k, o_playing); end
        end
        n_cmp++; if (o_dbg_pending !== 3'b001) begin n_err++; $display("FAIL cfg_pending_held: got %b want 001", o_dbg_pending); end
        i_cfg_done = 1'b1;
        cyc(1'b1, 3'b000, 1'b0);
        n_cmp++; if (o_rom_sel !== 3'b001) begin n_err++; $display("FAIL cfg_start_sel: got %b want 001", o_rom_sel); end
        n_cmp++; if (o_rom_addr !== 18'd0) begin n_err++; $display("FAIL cfg_start_addr: got %0d want 0", o_rom_addr); end
        // Dropping cfg_done mid-clip must not stop playback.
        i_cfg_done = 1'b0;
        cyc(1'b1, 3'b000, 1'b0);
        n_cmp++; if (o_playing !== 1'b1 || o_rom_addr !== 18'd1) begin n_err++; $display("FAIL cfg_drop_keeps_play: got playing=%b addr=%0d want 1/1", o_playing, o_rom_addr); end
        i_cfg_done = 1'b1;
        cyc(1'b0, 3'b000, 1'b1);
        n_cmp++; if (o_playing !== 1'b0) begin n_err++; $display("FAIL cfg_stop_idle: got %b want 0", o_playing); end
    endtask

    task automatic test_same_cycle_req;
        cyc(1'b1, 3'b001, 1'b0);
        n_cmp++; if (o_playing !== 1'b0 || o_dbg_pending !== 3'b001) begin n_err++; $display("FAIL samecyc_ignored: got playing=%b pend=%b want 0/001", o_playing, o_dbg_pending); end
        cyc(1'b1, 3'b000, 1'b0);
        n_cmp++; if (o_rom_sel !== 3'b001 || o_rom_addr !== 18'd0) begin n_err++; $display("FAIL samecyc_next_tick: got sel=%b addr=%0d want 001/0", o_rom_sel, o_rom_addr); end
        cyc(1'b0, 3'b000, 1'b1);
    endtask

    task automatic test_coin_natural;
        cyc(1'b0, 3'b001, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 3'b000, 1'b0);
            n_cmp++; if (o_rom_addr !== 18'(k) || o_rom_sel !== 3'b001 || o_done !== 3'b000) begin n_err++; $display("FAIL coin_addr%0d: got addr=%0d sel=%b done=%b want %0d/001/000", k, o_rom_addr, o_rom_sel, o_done, k); end
            cyc(1'b0, 3'b000, 1'b0);
            n_cmp++; if (o_rom_addr !== 18'(k)) begin n_err++; $display("FAIL coin_hold%0d: got %0d want %0d", k, o_rom_addr, k); end
        end
        cyc(1'b1, 3'b000, 1'b0);
        n_cmp++; if (o_done !== 3'b001) begin n_err++; $display("FAIL coin_done: got %b want 001", o_done); end
        n_cmp++; if (o_playing !== 1'b0 || o_rom_sel !== 3'b000 || o_rom_addr !== 18'd0) begin n_err++; $display("FAIL coin_idle: got playing=%b sel=%b addr=%0d want 0/000/0", o_playing, o_rom_sel, o_rom_addr); end
        cyc(1'b0, 3'b000, 1'b0);
        n_cmp++; if (o_done !== 3'b000) begin n_err++; $display("FAIL coin_done_width: got %b want 000", o_done); end
    endtask

    task automatic test_preempt;
        cyc(1'b0, 3'b001, 1'b0);
        cyc(1'b1, 3'b000, 1'b0);
        cyc(1'b1, 3'b000, 1'b0);
        cyc(1'b1, 3'b000, 1'b0);
        n_cmp++; if (o_rom_addr !== 18'd2) begin n_err++; $display("FAIL pre_coin_addr2: got %0d want 2", o_rom_addr); end
        cyc(1'b0, 3'b100, 1'b0);
        cyc(1'b1, 3'b000, 1'b0);
        n_cmp++; if (o_rom_sel !== 3'b100 || o_rom_addr !== 18'd0 || o_done !== 3'b000) begin n_err++; $display("FAIL pre_switch: got sel=%b addr=%0d done=%b want 100/0/000", o_rom_sel, o_rom_addr, o_done); end
        cyc(1'b1, 3'b000, 1'b0);
        cyc(1'b1, 3'b000, 1'b0);
        cyc(1'b1, 3'b000, 1'b0);
        n_cmp++; if (o_done !== 3'b100 || o_playing !== 1'b0) begin n_err++; $display("FAIL pre_go_end: got done=%b playing=%b want 100/0", o_done, o_playing); end
        cyc(1'b1, 3'b000, 1'b0);
        n_cmp++; if (o_playing !== 1'b0 || o_rom_sel !== 3'b000) begin n_err++; $display("FAIL pre_no_resume: got playing=%b sel=%b want 0/000", o_playing, o_rom_sel); end
    endtask

    task automatic test_back_to_back;
        cyc(1'b0, 3'b100, 1'b0);
        cyc(1'b1, 3'b000, 1'b0);
        cyc(1'b0, 3'b001, 1'b0);
        n_cmp++; if (o_rom_sel !== 3'b100 || o_dbg_pending !== 3'b001) begin n_err++; $display("FAIL b2b_coin_waits: got sel=%b pend=%b want 100/001", o_rom_sel, o_dbg_pending); end
        cyc(1'b1, 3'b000, 1'b0);
        cyc(1'b1, 3'b000, 1'b0);
        n_cmp++; if (o_rom_addr !== 18'd2 || o_rom_sel !== 3'b100) begin n_err++; $display("FAIL b2b_go_last: got addr=%0d sel=%b want 2/100", o_rom_addr, o_rom_sel); end
        cyc(1'b1, 3'b000, 1'b0);
        n_cmp++; if (o_done !== 3'b100 || o_rom_sel !== 3'b001 || o_rom_addr !== 18'd0 || o_playing !== 1'b1) begin n_err++; $display("FAIL b2b_chain: got done=%b sel=%b addr=%0d playing=%b want 100/001/0/1", o_done, o_rom_sel, o_rom_addr, o_playing); end
        for (int k = 0; k < 4; k++) cyc(1'b1, 3'b000, 1'b0);
        n_cmp++; if (o_done !== 3'b001 || o_playing !== 1'b0) begin n_err++; $display("FAIL b2b_coin_end: got done=%b playing=%b want 001/0", o_done, o_playing); end
    endtask

    task automatic test_stop;
        cyc(1'b0, 3'b010, 1'b0);
        cyc(1'b1, 3'b000, 1'b0);
        cyc(1'b0, 3'b001, 1'b0);
        n_cmp++; if (o_rom_sel !== 3'b010 || o_dbg_pending !== 3'b001) begin n_err++; $display("FAIL stop_setup: got sel=%b pend=%b want 010/001", o_rom_sel, o_dbg_pending); end
        cyc(1'b1, 3'b010, 1'b1);
        n_cmp++; if (o_playing !== 1'b0 || o_dbg_pending !== 3'b000 || o_done !== 3'b000 || o_rom_addr !== 18'd0) begin n_err++; $display("FAIL stop_flush: got playing=%b pend=%b done=%b addr=%0d want 0/000/000/0", o_playing, o_dbg_pending, o_done, o_rom_addr); end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 3'b000, 1'b0);
            n_cmp++; if (o_playing !== 1'b0) begin n_err++; $display("FAIL stop_no_start%0d: got %b want 0", k, o_playing); end
        end
    endtask

    task automatic test_retrigger;
        cyc(1'b0, 3'b010, 1'b0);
        cyc(1'b1, 3'b000, 1'b0);
        cyc(1'b1, 3'b000, 1'b0);
        cyc(1'b0, 3'b010, 1'b0);
        cyc(1'b1, 3'b000, 1'b0);
        n_cmp++; if (o_rom_sel !== 3'b010 || o_rom_addr !== 18'd0 || o_done !== 3'b000) begin n_err++; $display("FAIL retrig: got sel=%b addr=%0d done=%b want 010/0/000", o_rom_sel, o_rom_addr, o_done); end
        cyc(1'b0, 3'b000, 1'b1);
        cyc(1'b0, 3'b111, 1'b0);
        cyc(1'b1, 3'b000, 1'b0);
        n_cmp++; if (o_rom_sel !== 3'b100 || o_dbg_pending !== 3'b011) begin n_err++; $display("FAIL simul_req: got sel=%b pend=%b want 100/011", o_rom_sel, o_dbg_pending); end
        cyc(1'b0, 3'b000, 1'b1);
    endtask

    task automatic test_reset_midclip;
        cyc(1'b0, 3'b001, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b1, 3'b000, 1'b0);
        n_cmp++; if (o_rom_addr !== 18'd3) begin n_err++; $display("FAIL midrst_addr3: got %0d want 3", o_rom_addr); end
        reset = 1'b1;
        cyc(1'b1, 3'b000, 1'b0);
        reset = 1'b0;
        n_cmp++; if (o_playing !== 1'b0 || o_rom_rden !== 1'b0 || o_rom_sel !== 3'b000 || o_rom_addr !== 18'd0 || o_done !== 3'b000) begin n_err++; $display("FAIL midrst_outputs: got play=%b rden=%b sel=%b addr=%0d done=%b want all 0", o_playing, o_rom_rden, o_rom_sel, o_rom_addr, o_done); end
        cyc(1'b0, 3'b001, 1'b0);
        cyc(1'b1, 3'b000, 1'b0);
        n_cmp++; if (o_rom_sel !== 3'b001 || o_rom_addr !== 18'd0) begin n_err++; $display("FAIL midrst_replay: got sel=%b addr=%0d want 001/0", o_rom_sel, o_rom_addr); end
        cyc(1'b0, 3'b000, 1'b1);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset         = 1'b1;
        i_cfg_done    = 1'b1;
        i_sample_tick = 1'b0;
        i_req         = 3'b000;
        i_stop        = 1'b0;
        test_reset();
        test_cfg_gate();
        test_same_cycle_req();
        test_coin_natural();
        test_preempt();
        test_back_to_back();
        test_stop();
        test_retrigger();
        test_reset_midclip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
